pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Fetch-side controller that drives the write port of the program counter register (pc_write, pc_next) and reads its output (pc_result).
- Each cycle of operation: fetch one instruction at pc_result from instruction memory (valid/ready request, valid-only response), present it to decode with a valid/ready handshake, then advance the PC.
- Branch/jump redirects from execute override sequential advance.
- Sits between the PC register, instruction memory and the decoder.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words
- RESET_PC, 32'h0000_0000, PC value loaded after reset
- INSTR_BYTES, 4, sequential PC increment

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_result  in  XLEN  current PC from PC register (updates the edge after pc_write)
- pc_write  out  1  one-cycle load strobe to PC register
- pc_next  out  XLEN  value loaded when pc_write=1
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc_result)
- imem_rsp_valid  in  1  read data valid (one pulse per accepted request)
- imem_rsp_data  in  XLEN  instruction word
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts instruction
- instr_data  out  XLEN  held instruction
- instr_pc  out  XLEN  PC of held instruction
- redirect_valid  in  1  control-flow redirect, single-cycle pulse
- redirect_pc  in  XLEN  redirect target

Behaviour:
- Outputs are combinational from state and inputs; instr_data and instr_pc are registers.
- FSM states: BOOT, REQ, WAIT, DROP, HOLD.
- Reset: state=BOOT; instr_data=0, instr_pc=0; imem_req_valid=0, instr_valid=0.
- BOOT (one cycle): pc_write=1, pc_next=RESET_PC. Redirect and rsp ignored. Next state is REQ.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc_result.
  - req_valid && req_ready -> WAIT; capture pc_result into instr_pc.
  - Redirect in REQ: imem_req_valid forced 0 that cycle; pc_write=1, pc_next=redirect_pc; stay REQ, so the next cycle requests the new pc_result.
- WAIT:
  - imem_rsp_valid is only honoured in WAIT/DROP; memory must not respond in the acceptance cycle.
  - rsp_valid without redirect -> capture imem_rsp_data into instr_data -> HOLD.
  - Redirect without rsp: pc_write=1 with redirect_pc -> DROP.
  - Redirect with rsp in the same cycle: discard data, pc_write with redirect_pc -> REQ.
- DROP:
  - Wait for the outstanding response and discard it.
  - rsp_valid -> REQ.
  - Further redirect: pc_write=1 with the newest redirect_pc, stay DROP (or -> REQ if rsp arrives in the same cycle).
  - Exactly one response is discarded per outstanding request.
- HOLD:
  - instr_valid=1; instr_data/instr_pc stable until transfer.
  - instr_ready=1 -> transfer; pc_write=1, pc_next=instr_pc+INSTR_BYTES (mod 2^XLEN) -> REQ.
  - Redirect (with or without instr_ready): the transfer still completes if instr_ready=1; pc_write=1 with pc_next=redirect_pc, which has priority over the increment -> REQ.
  - Redirect without ready: held instruction dropped, instr_valid low next cycle.
- pc_write never asserts for more than one cycle except in back-to-back redirects.
- At most one memory request outstanding.
- Minimum throughput: 3 cycles per instruction (REQ, WAIT, HOLD).
- Wrap-around: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
- Reset asserted mid-operation: state -> BOOT next edge regardless of outstanding request. Instruction memory is reset by the same rst; stale responses after reset are ignored in BOOT.

Test Plan:
- Reset then free-run: rst 2 cycles, req_ready=1, rsp 1 cycle later, instr_ready=1.
  -> pc_write in BOOT with pc_next=0; fetch addrs 0,4,8,C; instr_pc matches; 3 cycles per instr.
- Backpressure: instr_ready=0 for 5 cycles in HOLD with data 32'hDEAD_BEEF at pc 8.
  -> instr_valid, data and pc stable for 5 cycles, no pc_write until ready, then pc_next=C.
- Request stall: req_ready=0 for 4 cycles at pc 10.
  -> imem_req_valid/addr=10 held, no pc_write, proceeds on ready.
- Redirect during WAIT at pc 4 to 32'h100, rsp 2 cycles later.
  -> pc_write pc_next=100 in the redirect cycle; response discarded (no instr_valid); next request addr=100.
- Redirect coincident with instr_ready in HOLD (pc 20, target 40).
  -> transfer of pc 20 occurs, pc_next=40 not 24; next fetch addr=40. Repeat with instr_ready=0 -> no transfer, pc_next=40.
- Wrap and mid-op reset: start at pc FFFF_FFFC -> pc_next=0. Then assert rst in WAIT -> BOOT, pc_next=RESET_PC, no instr_valid from the stale response.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-side controller: one outstanding instruction-memory request, a single
// held instruction for decode, and PC advance or redirect via the PC register.
module pc_fetch_ctrl #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter int               INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_result,
    output logic            pc_write,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [2:0] {BOOT, REQ, WAIT, DROP, HOLD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] instr_data_q, instr_data_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            instr_data_q <= '0;
            instr_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            instr_data_q <= instr_data_d;
            instr_pc_q   <= instr_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_data_d = instr_data_q;
        instr_pc_d   = instr_pc_q;
        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (!redirect_valid && imem_req_ready) begin
                    state_d    = WAIT;
                    instr_pc_d = pc_result;
                end
            end
            WAIT: begin
                if (imem_rsp_valid && !redirect_valid) begin
                    state_d      = HOLD;
                    instr_data_d = imem_rsp_data;
                end else if (redirect_valid && !imem_rsp_valid) begin
                    state_d = DROP;
                end else if (redirect_valid && imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            // the single outstanding response is swallowed here
            DROP: if (imem_rsp_valid) state_d = REQ;
            HOLD: if (redirect_valid || instr_ready) state_d = REQ;
            default: state_d = BOOT;
        endcase
    end

    // strobes are held low while rst is asserted so nothing leaks before BOOT
    always_comb begin
        pc_write       = 1'b0;
        pc_next        = '0;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        if (!rst) begin
            case (state_q)
                BOOT: begin
                    pc_write = 1'b1;
                    pc_next  = RESET_PC;
                end
                REQ: begin
                    imem_req_valid = !redirect_valid;
                    if (redirect_valid) begin
                        pc_write = 1'b1;
                        pc_next  = redirect_pc;
                    end
                end
                WAIT, DROP: begin
                    if (redirect_valid) begin
                        pc_write = 1'b1;
                        pc_next  = redirect_pc;
                    end
                end
                HOLD: begin
                    instr_valid = 1'b1;
                    if (redirect_valid) begin
                        pc_write = 1'b1;
                        pc_next  = redirect_pc;
                    end else if (instr_ready) begin
                        pc_write = 1'b1;
                        pc_next  = instr_pc_q + XLEN'(INSTR_BYTES);
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req_addr = pc_result;
    assign instr_data    = instr_data_q;
    assign instr_pc      = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: models the PC register and a one-outstanding memory,
// and scoreboards pc_write values, request addresses and decode transfers.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_result = 32'hBAD0_0000;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000), .INSTR_BYTES(4)) dut (
        .clk(clk), .rst(rst), .pc_result(pc_result), .pc_write(pc_write), .pc_next(pc_next),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; logic [31:0] data;} xfer_t;

    logic [31:0] exp_pcw[$];
    logic [31:0] exp_req[$];
    xfer_t       exp_xfer[$];
    int          xfer_cyc[$];
    int n_chk = 0, n_err = 0;
    int cyc = 0, n_acc = 0, n_xfer = 0;
    int rsp_delay = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h8) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0F0F);
    endfunction

    task automatic push_x(input logic [31:0] pc);
        xfer_t x;
        x.pc = pc;
        x.data = memf(pc);
        exp_xfer.push_back(x);
    endtask

    // monitor samples mid-cycle; PC register and memory update just after the edge
    logic        s_pw = 1'b0, s_acc = 1'b0;
    logic [31:0] s_pn = '0, s_addr = '0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    always @(negedge clk) begin
        cyc++;
        s_pw = pc_write;
        s_pn = pc_next;
        s_acc = imem_req_valid && imem_req_ready;
        s_addr = imem_req_addr;
        if (!rst) begin
            if (pc_write) begin
                if (exp_pcw.size() == 0) chk("pcw_unexp", {31'b0, pc_write}, 32'h0);
                else chk("pc_next", pc_next, exp_pcw.pop_front());
            end
            if (s_acc) begin
                n_acc++;
                if (exp_req.size() == 0) chk("req_unexp", {31'b0, imem_req_valid}, 32'h0);
                else chk("req_addr", imem_req_addr, exp_req.pop_front());
            end
            if (instr_valid && instr_ready) begin
                xfer_t x;
                n_xfer++;
                xfer_cyc.push_back(cyc);
                if (exp_xfer.size() == 0) chk("xfer_unexp", {31'b0, instr_valid}, 32'h0);
                else begin
                    x = exp_xfer.pop_front();
                    chk("xfer_pc", instr_pc, x.pc);
                    chk("xfer_data", instr_data, x.data);
                end
            end
        end
    end

    // memory is deliberately not cleared by rst so a stale response can reach BOOT
    always @(posedge clk) begin
        #1;
        if (s_pw) pc_result = s_pn;
        imem_rsp_valid = 1'b0;
        if (s_acc) begin
            pend = 1'b1;
            cnt = rsp_delay;
            paddr = s_addr;
        end
        if (pend) begin
            if (cnt <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = memf(paddr);
                pend = 1'b0;
            end else cnt--;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_xfer(input int n);
        for (int i = 0; i < 60 && n_xfer < n; i++) tick();
        if (n_xfer < n) chk("tmo_xfer", n_xfer, n);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 60 && n_acc < n; i++) tick();
        if (n_acc < n) chk("tmo_acc", n_acc, n);
    endtask

    task automatic wait_hold;
        for (int i = 0; i < 60 && !instr_valid; i++) tick();
        if (!instr_valid) chk("tmo_hold", {31'b0, instr_valid}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_pcw", {31'b0, pc_write}, 32'h0);
        chk("rst_reqv", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_iv", {31'b0, instr_valid}, 32'h0);
        chk("rst_data", instr_data, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);

        // free run 0,4 then backpressure at 8 and request stall at 10
        exp_pcw.push_back(32'h0);
        for (int i = 1; i <= 5; i++) exp_pcw.push_back(32'(4 * i));
        for (int i = 0; i <= 5; i++) exp_req.push_back(32'(4 * i));
        for (int i = 0; i <= 4; i++) push_x(32'(4 * i));
        rst = 1'b0;

        wait_xfer(2);
        instr_ready = 1'b0;
        wait_hold();
        for (int i = 0; i < 5; i++) begin
            chk("bp_iv", {31'b0, instr_valid}, 32'h1);
            chk("bp_data", instr_data, 32'hDEAD_BEEF);
            chk("bp_pc", instr_pc, 32'h8);
            chk("bp_pcw", {31'b0, pc_write}, 32'h0);
            tick();
        end
        instr_ready = 1'b1;
        chk("cpi_a", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);

        wait_xfer(4);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_reqv", {31'b0, imem_req_valid}, 32'h1);
            chk("stall_addr", imem_req_addr, 32'h10);
            chk("stall_pcw", {31'b0, pc_write}, 32'h0);
            tick();
        end
        imem_req_ready = 1'b1;
        chk("cpi_b", 32'(xfer_cyc[3] - xfer_cyc[2]), 32'd3);

        // redirect in WAIT at pc 14; its late response must be discarded
        wait_xfer(5);
        rsp_delay = 3;
        exp_pcw.push_back(32'h100);
        exp_req.push_back(32'h100);
        push_x(32'h100);
        wait_acc(6);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        rsp_delay = 1;
        for (int i = 0; i < 3; i++) begin
            chk("drop_iv", {31'b0, instr_valid}, 32'h0);
            tick();
        end

        // redirect in HOLD with ready (transfer + redirect), then without ready
        exp_pcw.push_back(32'h40);
        exp_req.push_back(32'h40);
        exp_pcw.push_back(32'h40);
        exp_req.push_back(32'h40);
        push_x(32'h40);
        exp_pcw.push_back(32'h44);
        wait_hold();
        chk("hold_pc", instr_pc, 32'h100);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        wait_hold();
        chk("hold2_pc", instr_pc, 32'h40);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("hold2_drop", {31'b0, instr_valid}, 32'h0);
        instr_ready = 1'b1;

        // redirect in REQ to the top of memory, wrap to 0, then reset in WAIT
        exp_pcw.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'hFFFF_FFFC);
        push_x(32'hFFFF_FFFC);
        exp_pcw.push_back(32'h0);
        exp_req.push_back(32'h0);
        wait_xfer(7);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("req_kill", {31'b0, imem_req_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        wait_xfer(8);
        rsp_delay = 2;
        wait_acc(11);
        rst = 1'b1;
        exp_pcw.push_back(32'h0);
        exp_req.push_back(32'h0);
        push_x(32'h0);
        exp_pcw.push_back(32'h4);
        #1;
        chk("mrst_pcw", {31'b0, pc_write}, 32'h0);
        chk("mrst_iv", {31'b0, instr_valid}, 32'h0);
        tick();
        rst = 1'b0;
        rsp_delay = 1;
        wait_xfer(9);
        imem_req_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("left_pcw", 32'(exp_pcw.size()), 32'd0);
        chk("left_req", 32'(exp_req.size()), 32'd0);
        chk("left_xfer", 32'(exp_xfer.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
